// File: rtl/pipeline_control_unit.sv
// Pipeline control: stall/branch to PC/IF-ID/ID-EX controls, EX/MEM/WB dest history.
// Optional saturating stall-cycle counter enabled by defining PIPE_STALL_COUNTER_EN.
module pipeline_control_unit #(
   parameter int WIDTH      = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pipeline_stall_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_op_dest,
   input  logic                  branch_taken,
   output logic                  pc_en,
   output logic                  ifid_en,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic [REG_ADDR_W-1:0] ex_op_dest,
   output logic [REG_ADDR_W-1:0] mem_op_dest,
   output logic [REG_ADDR_W-1:0] wb_op_dest,
   output logic [1:0]            ctrl_state
`ifdef PIPE_STALL_COUNTER_EN
   ,
   output logic [15:0]           stall_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   if (WIDTH < 1 || REG_ADDR_W < 1) begin : g_param_check
      $error("pipeline_control_unit: WIDTH and REG_ADDR_W must be positive");
   end

   logic   stall;
   logic   flush;
   state_t state_q;
   state_t state_d;

   assign stall = !pipeline_stall_n;
   assign flush = branch_taken;

   // A taken branch squashes whatever ID holds, so it overrides any stall.
   always_comb begin
      pc_en       = !stall || flush;
      ifid_en     = !stall || flush;
      ifid_flush  = flush;
      idex_bubble = flush || stall || !id_valid;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, which keeps the shift chain a true shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_op_dest  <= '0;
         mem_op_dest <= '0;
         wb_op_dest  <= '0;
      end else begin
         ex_op_dest  <= idex_bubble ? '0 : id_op_dest;
         mem_op_dest <= ex_op_dest;
         wb_op_dest  <= mem_op_dest;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // Next state depends only on the cause seen this cycle, not on the current state.
   always_comb begin
      state_d = ST_RUN;
      if (flush)      state_d = ST_FLUSH;
      else if (stall) state_d = ST_STALL;
   end

   always_comb begin
      ctrl_state = state_q;
   end

`ifdef PIPE_STALL_COUNTER_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (stall && !flush && stall_cycles != 16'hFFFF)
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit: directed cases with literal
// expectations plus random stimulus compared every cycle against a behavioural model.
module tb_pipeline_control_unit;

   localparam int RW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pipeline_stall_n;
   logic          id_valid;
   logic [RW-1:0] id_op_dest;
   logic          branch_taken;
   logic          pc_en, ifid_en, ifid_flush, idex_bubble;
   logic [RW-1:0] ex_op_dest, mem_op_dest, wb_op_dest;
   logic [1:0]    ctrl_state;
`ifdef PIPE_STALL_COUNTER_EN
   logic [15:0]   stall_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pipeline_control_unit #(.WIDTH(8), .REG_ADDR_W(RW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pipeline_stall_n (pipeline_stall_n),
      .id_valid         (id_valid),
      .id_op_dest       (id_op_dest),
      .branch_taken     (branch_taken),
      .pc_en            (pc_en),
      .ifid_en          (ifid_en),
      .ifid_flush       (ifid_flush),
      .idex_bubble      (idex_bubble),
      .ex_op_dest       (ex_op_dest),
      .mem_op_dest      (mem_op_dest),
      .wb_op_dest       (wb_op_dest),
      .ctrl_state       (ctrl_state)
`ifdef PIPE_STALL_COUNTER_EN
      ,
      .stall_cycles     (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: history of issued dests (newest first), last cause, stall count.
   int m_hist [3];
   int m_state;
   int m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hist  <= '{0, 0, 0};
         m_state <= 0;
         m_cnt   <= 0;
      end else begin
         m_hist[0] <= (branch_taken || !pipeline_stall_n || !id_valid) ? 0 : int'(id_op_dest);
         m_hist[1] <= m_hist[0];
         m_hist[2] <= m_hist[1];
         m_state   <= branch_taken ? 2 : (!pipeline_stall_n ? 1 : 0);
         if (!pipeline_stall_n && !branch_taken && m_cnt < 65535) m_cnt <= m_cnt + 1;
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      bit s, f;
      s = !pipeline_stall_n;
      f = branch_taken;
      check("m_pc_en",       int'(pc_en),       int'(!s || f));
      check("m_ifid_en",     int'(ifid_en),     int'(!s || f));
      check("m_ifid_flush",  int'(ifid_flush),  int'(f));
      check("m_idex_bubble", int'(idex_bubble), int'(f || s || !id_valid));
      check("m_ex_dest",     int'(ex_op_dest),  m_hist[0]);
      check("m_mem_dest",    int'(mem_op_dest), m_hist[1]);
      check("m_wb_dest",     int'(wb_op_dest),  m_hist[2]);
      check("m_state",       int'(ctrl_state),  m_state);
`ifdef PIPE_STALL_COUNTER_EN
      check("m_stall_cycles", int'(stall_cycles), m_cnt);
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int c0;

   initial begin
      rst_n = 1'b1;
      pipeline_stall_n = 1'b1;
      branch_taken = 1'b0;
      id_valid = 1'b1;
      id_op_dest = 3'd5;
      #2 rst_n = 1'b0;
      repeat (3) step();
      #1;
      check("rst_ex",    int'(ex_op_dest), 0);
      check("rst_mem",   int'(mem_op_dest), 0);
      check("rst_wb",    int'(wb_op_dest), 0);
      check("rst_state", int'(ctrl_state), 0);
      check("rst_pc_en", int'(pc_en), 1);
`ifdef PIPE_STALL_COUNTER_EN
      check("rst_cnt",   int'(stall_cycles), 0);
`endif
      rst_n = 1'b1;
      step();
      check("rel_ex5", int'(ex_op_dest), 5);

      // Shift chain
      id_op_dest = 3'd3; step();
      id_op_dest = 3'd4; step();
      id_op_dest = 3'd6; step();
      check("shift_ex",  int'(ex_op_dest), 6);
      check("shift_mem", int'(mem_op_dest), 4);
      check("shift_wb",  int'(wb_op_dest), 3);

      // Back-to-back dependency: three stalled cycles inject three bubbles
      id_op_dest = 3'd3; step();
      id_op_dest = 3'd1;
      pipeline_stall_n = 1'b0;
`ifdef PIPE_STALL_COUNTER_EN
      c0 = int'(stall_cycles);
`endif
      for (int i = 0; i < 3; i++) begin
         #1;
         check("dep_pc_en",   int'(pc_en), 0);
         check("dep_ifid_en", int'(ifid_en), 0);
         check("dep_bubble",  int'(idex_bubble), 1);
         step();
         check("dep_ex0",     int'(ex_op_dest), 0);
         check("dep_state",   int'(ctrl_state), 1);
      end
      pipeline_stall_n = 1'b1;
      #1;
      check("dep_release", int'(pc_en), 1);
`ifdef PIPE_STALL_COUNTER_EN
      check("dep_cnt", int'(stall_cycles), c0 + 3);
`endif
      step();
      check("dep_issue", int'(ex_op_dest), 1);

      // Branch taken for one cycle
      id_op_dest = 3'd2;
      branch_taken = 1'b1;
      #1;
      check("br_flush",  int'(ifid_flush), 1);
      check("br_bubble", int'(idex_bubble), 1);
      check("br_pc_en",  int'(pc_en), 1);
      step();
      branch_taken = 1'b0;
      id_op_dest = 3'd4;
      check("br_ex0",   int'(ex_op_dest), 0);
      check("br_state", int'(ctrl_state), 2);
      step();
      check("br_run",   int'(ctrl_state), 0);
      check("br_ex4",   int'(ex_op_dest), 4);

      // Stall and branch together behave as a flush
      pipeline_stall_n = 1'b0;
      branch_taken = 1'b1;
`ifdef PIPE_STALL_COUNTER_EN
      c0 = int'(stall_cycles);
`endif
      #1;
      check("pri_pc_en", int'(pc_en), 1);
      check("pri_flush", int'(ifid_flush), 1);
      check("pri_bubble", int'(idex_bubble), 1);
      step();
      pipeline_stall_n = 1'b1;
      branch_taken = 1'b0;
      check("pri_state", int'(ctrl_state), 2);
      check("pri_ex0",   int'(ex_op_dest), 0);
`ifdef PIPE_STALL_COUNTER_EN
      check("pri_cnt",   int'(stall_cycles), c0);
`endif

      // Random traffic, checked by the compare process
      repeat (600) begin
         pipeline_stall_n = ($urandom_range(0, 3) != 0);
         branch_taken     = ($urandom_range(0, 7) == 0);
         id_valid         = ($urandom_range(0, 5) != 0);
         id_op_dest       = RW'($urandom_range(0, 7));
         step();
      end

      // Reset in the middle of a stall clears history at once
      pipeline_stall_n = 1'b1;
      branch_taken = 1'b0;
      id_valid = 1'b1;
      id_op_dest = 3'd3;
      step(); step();
      pipeline_stall_n = 1'b0;
      step();
      check("mid_mem3", int'(mem_op_dest), 3);
      #1 rst_n = 1'b0;
      #1;
      check("mid_ex",    int'(ex_op_dest), 0);
      check("mid_mem",   int'(mem_op_dest), 0);
      check("mid_wb",    int'(wb_op_dest), 0);
      check("mid_state", int'(ctrl_state), 0);
`ifdef PIPE_STALL_COUNTER_EN
      check("mid_cnt",   int'(stall_cycles), 0);
`endif
      pipeline_stall_n = 1'b1;
      #1 rst_n = 1'b1;
      step();

`ifdef PIPE_STALL_COUNTER_EN
      // Saturation of the stall counter
      pipeline_stall_n = 1'b0;
      repeat (65540) step();
      check("sat_cnt", int'(stall_cycles), 65535);
      #1 rst_n = 1'b0;
      #1;
      check("sat_rst", int'(stall_cycles), 0);
      pipeline_stall_n = 1'b1;
      #1 rst_n = 1'b1;
      step();
`endif

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Consumer of `pipeline_stall_n` and producer of the destination-register history compared against by the hazard checker in the 8-bit pipelined core. It tracks the destination register of the instruction in each of the EX, MEM and WB stages. It converts stall and branch-taken events into PC/IF-ID enables, an IF/ID flush and an ID/EX bubble. It also keeps an optional stall-cycle performance counter.

## Interface
- `WIDTH`, 8: datapath width; sizes nothing internally, kept for consistency.
- `REG_ADDR_W`, 3: register-number width. Register 0 means "no write".
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pipeline_stall_n` in 1: active-low stall from the hazard checker (combinational, same cycle).
- `id_valid` in 1: the ID stage holds a real instruction. A value of 0 is treated as NOP.
- `id_op_dest` in REG_ADDR_W: destination register of the ID-stage instruction. It is 0 for ST, BZ and NOP.
- `branch_taken` in 1: the BZ in EX resolved taken this cycle.
- `pc_en` out 1: PC register enable.
- `ifid_en` out 1: IF/ID register enable.
- `ifid_flush` out 1: load a NOP into IF/ID at the next edge.
- `idex_bubble` out 1: load a NOP (`OP_NOP`, dest 0) into ID/EX at the next edge.
- `ex_op_dest` out REG_ADDR_W: destination register of the EX-stage instruction.
- `mem_op_dest` out REG_ADDR_W: destination register of the MEM-stage instruction.
- `wb_op_dest` out REG_ADDR_W: destination register of the WB-stage instruction.
- `ctrl_state` out 2: current FSM state (RUN=0, STALL=1, FLUSH=2).
- `stall_cycles` out 16: saturating stall counter. Present only with the macro (see Configuration).

## Operation
- **stall** = `!pipeline_stall_n`; **flush** = `branch_taken`. Flush has priority over stall.
- **Combinational outputs:**
  - `pc_en = !stall | flush`
  - `ifid_en = !stall | flush`
  - `ifid_flush = flush`
  - `idex_bubble = flush | stall | !id_valid`
- **Destination shift, on each edge, always (never held):**
  - `wb_op_dest <= mem_op_dest`
  - `mem_op_dest <= ex_op_dest`
  - `ex_op_dest <= idex_bubble ? 0 : id_op_dest`
- Bubbles drain EX→MEM→WB with dest 0. Any stall therefore self-clears within 3 cycles, so there is no deadlock.
- **FSM, registered, reflecting the cause applied at the last edge:**
  - Any state → FLUSH if flush.
  - Else → STALL if stall.
  - Else → RUN.
  - FLUSH lasts exactly one cycle unless `branch_taken` repeats.
- `ctrl_state` is a debug/observation output only. It does not gate any other output.

## Timing
- **Reset (async assert, sync-release use):**
  - `ex_op_dest`, `mem_op_dest`, `wb_op_dest` = 0.
  - `ctrl_state` = RUN.
  - `stall_cycles` = 0.
  - Combinational outputs follow their inputs during reset.
- **Latency:** the ID dest appears on `ex_op_dest` 1 edge later, `mem_op_dest` 2 edges later, `wb_op_dest` 3 edges later.
- **Back-to-back dependency** (ID reads the reg written by EX):
  - Stall is asserted for exactly 3 cycles (EX, MEM and WB matches in turn).
  - Release happens in the 4th cycle.
- **Reset mid-stall:** the history clears immediately, so the hazard checker sees no match and `pipeline_stall_n` returns to 1 the same cycle.
- **Simultaneous stall and branch_taken:** treated as a flush. `pc_en=1`, `ifid_flush=1`, `idex_bubble=1`, `stall_cycles` not incremented.

## Configuration
- `PIPE_STALL_COUNTER_EN` defined:
  - `stall_cycles` exists.
  - It increments by 1 on each edge where stall is applied (stall && !flush).
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined: the `stall_cycles` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst_n`=0 with `id_valid`=1, `id_op_dest`=5 → all dest outputs 0, `ctrl_state`=0. After release, `ex_op_dest`=5 at the first edge.
- **Shift:** issue dests 3, 4, 6 on consecutive cycles with no stall → at the 3rd edge `ex`=6, `mem`=4, `wb`=3.
- **Dependency:** issue dest 3, then an ID instruction reading r3 (stall from the checker) → `pc_en`=0 for 3 cycles, `ex_op_dest` = 0,0,0 inserted. Release in cycle 4; `stall_cycles`=3.
- **Branch:** pulse `branch_taken` for 1 cycle with ID dest 2 → `ifid_flush`=1 and `idex_bubble`=1. Next `ex_op_dest`=0 and `ctrl_state`=FLUSH for 1 cycle, then RUN.
- **Priority:** assert stall and `branch_taken` together → `pc_en`=1, `ifid_flush`=1, `stall_cycles` unchanged, state FLUSH.
- **Saturation:** with the macro defined, force stall for 70000 cycles → `stall_cycles`=16'hFFFF. Assert reset mid-stall → 0 immediately.
